servo_pid_multicanal: RTL and testbench

- Parametrised successor to the single-channel servo loop.
- Computes an incremental (velocity-form) PID law for N_CH independent servo channels from one shared multiplier.
- Each channel uses its own reference, potentiometer feedback, history and output.
- One Rx_Tick starts one control period for all channels; results appear together with a one-cycle Listo pulse.
- Sits between the ADC/UART sample path (Rx_Tick) and the PWM generators.

---
 rtl/servo_pid_multicanal.sv | 232 +++++++++++++++++++++++
 tb/tb_servo_pid_multicanal.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pid_multicanal.sv
// servo_pid_multicanal
// Incremental (velocity-form) PID for N_CH servo channels sharing one
// multiplier. One Rx_Tick runs a control period over every channel in turn
// (ERR, MAC0, MAC1, MAC2, STORE per channel). All outputs then update
// together in DONE, and Listo pulses in that same cycle.
//
// Ports
//   Clk_P, Rst_P         clock (rising edge) / async active-low reset
//   Rx_Tick              one-cycle strobe that starts a control period
//   Modo                 0 = closed-loop PID, 1 = bypass (YkT = Ref)
//   Ref_P, Pot_P         packed signed reference / feedback, CANT_BITS each
//   Coef_A0..A2          shared signed coefficients, FRAC_BITS fractional
//   YkT                  packed signed controller outputs
//   Listo                high in the cycle YkT/Saturado carry new values
//   Ocupado              high while a period is in progress
//   Overrun              one-cycle pulse for a tick arriving while busy
//   Saturado             per channel: last update clipped error or output
module servo_pid_multicanal #(
  parameter int CANT_BITS = 13,
  parameter int FRAC_BITS = 8,
  parameter int N_CH      = 2
) (
  input  logic                        Clk_P,
  input  logic                        Rst_P,
  input  logic                        Rx_Tick,
  input  logic                        Modo,
  input  logic [N_CH*CANT_BITS-1:0]   Ref_P,
  input  logic [N_CH*CANT_BITS-1:0]   Pot_P,
  input  logic [CANT_BITS-1:0]        Coef_A0,
  input  logic [CANT_BITS-1:0]        Coef_A1,
  input  logic [CANT_BITS-1:0]        Coef_A2,
  output logic [N_CH*CANT_BITS-1:0]   YkT,
  output logic                        Listo,
  output logic                        Ocupado,
  output logic                        Overrun,
  output logic [N_CH-1:0]             Saturado
);

  localparam int CB = CANT_BITS;
  localparam int AW = 2*CANT_BITS + 2;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CB-1:0] MAXV = {1'b0, {(CB-1){1'b1}}};
  localparam logic [CB-1:0] MINV = {1'b1, {(CB-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MAC0, S_MAC1, S_MAC2, S_STORE, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             c_q, c_d;
  logic signed [AW-1:0]      acc_q, acc_d;
  logic signed [CB-1:0]      e_q, e_d;
  logic                      satp_q, satp_d;
  logic [N_CH*CB-1:0]        ref_q, ref_d, pot_q, pot_d;
  logic signed [CB-1:0]      a0_q, a0_d, a1_q, a1_d, a2_q, a2_d;
  logic                      modo_q, modo_d;
  logic signed [CB-1:0]      e1_q [N_CH];
  logic signed [CB-1:0]      e1_d [N_CH];
  logic signed [CB-1:0]      e2_q [N_CH];
  logic signed [CB-1:0]      e2_d [N_CH];
  logic signed [CB-1:0]      y1_q [N_CH];
  logic signed [CB-1:0]      y1_d [N_CH];
  logic signed [CB-1:0]      stg_q [N_CH];
  logic signed [CB-1:0]      stg_d [N_CH];
  logic [N_CH-1:0]           stg_sat_q, stg_sat_d;
  logic [N_CH*CB-1:0]        ykt_q, ykt_d;
  logic [N_CH-1:0]           satu_q, satu_d;
  logic                      ovr_q, ovr_d;

  logic signed [CB-1:0]      ref_c, pot_c, mul_a, mul_b, y1_c, e_sat, y_sat, y_new;
  logic signed [2*CB-1:0]    prod;
  logic [CB:0]               diff;
  logic                      e_clip, y_ovf, last_ch, sat_new;
  logic signed [AW-1:0]      sh;
  logic [AW-CB:0]            sh_hi;

  assign ref_c = ref_q[c_q*CB +: CB];
  assign pot_c = pot_q[c_q*CB +: CB];
  assign y1_c  = y1_q[c_q];

  // Error at CB+1 bits, clipped back to CB bits.
  assign diff   = {ref_c[CB-1], ref_c} - {pot_c[CB-1], pot_c};
  assign e_clip = diff[CB] != diff[CB-1];
  assign e_sat  = e_clip ? (diff[CB] ? MINV : MAXV) : diff[CB-1:0];

  // Shared multiplier: operands steered by the MAC state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MAC0: begin mul_a = a0_q; mul_b = e_q;        end
      S_MAC1: begin mul_a = a1_q; mul_b = e1_q[c_q];  end
      S_MAC2: begin mul_a = a2_q; mul_b = e2_q[c_q];  end
      default: ;
    endcase
  end
  assign prod = mul_a * mul_b;

  // Output: floor shift, then clip when the upper bits are not a pure sign extension.
  assign sh    = acc_q >>> FRAC_BITS;
  assign sh_hi = sh[AW-1:CB-1];
  assign y_ovf = !((&sh_hi) || !(|sh_hi));
  assign y_sat = y_ovf ? (sh[AW-1] ? MINV : MAXV) : sh[CB-1:0];

  assign last_ch = (c_q == CW'(N_CH-1));
  assign y_new   = modo_q ? ref_c : y_sat;
  assign sat_new = modo_q ? 1'b0 : (satp_q | y_ovf);

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    acc_d     = acc_q;
    e_d       = e_q;
    satp_d    = satp_q;
    ref_d     = ref_q;
    pot_d     = pot_q;
    a0_d      = a0_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    modo_d    = modo_q;
    e1_d      = e1_q;
    e2_d      = e2_q;
    y1_d      = y1_q;
    stg_d     = stg_q;
    stg_sat_d = stg_sat_q;
    ykt_d     = ykt_q;
    satu_d    = satu_q;
    ovr_d     = Rx_Tick && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (Rx_Tick) begin
          ref_d   = Ref_P;
          pot_d   = Pot_P;
          a0_d    = Coef_A0;
          a1_d    = Coef_A1;
          a2_d    = Coef_A2;
          modo_d  = Modo;
          c_d     = '0;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        e_d     = e_sat;
        satp_d  = e_clip;
        acc_d   = {{(AW-CB-FRAC_BITS){y1_c[CB-1]}}, y1_c, {FRAC_BITS{1'b0}}};
        state_d = S_MAC0;
      end
      S_MAC0, S_MAC1, S_MAC2: begin
        acc_d   = acc_q + {{2{prod[2*CB-1]}}, prod};
        state_d = (state_q == S_MAC0) ? S_MAC1 :
                  (state_q == S_MAC1) ? S_MAC2 : S_STORE;
      end
      S_STORE: begin
        stg_d[c_q]     = y_new;
        stg_sat_d[c_q] = sat_new;
        if (!modo_q) begin
          y1_d[c_q] = y_sat;
          e2_d[c_q] = e1_q[c_q];
          e1_d[c_q] = e_q;
        end
        if (last_ch) begin
          // Outputs load on entry to DONE so they are valid while Listo is high.
          for (int unsigned i = 0; i < N_CH; i++) begin
            ykt_d[i*CB +: CB] = stg_d[i];
          end
          satu_d  = stg_sat_d;
          c_d     = '0;
          state_d = S_DONE;
        end else begin
          c_d     = c_q + 1'b1;
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_P or negedge Rst_P) begin
    if (!Rst_P) begin
      state_q   <= S_IDLE;
      c_q       <= '0;
      acc_q     <= '0;
      e_q       <= '0;
      satp_q    <= 1'b0;
      ref_q     <= '0;
      pot_q     <= '0;
      a0_q      <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      modo_q    <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        e1_q[i]  <= '0;
        e2_q[i]  <= '0;
        y1_q[i]  <= '0;
        stg_q[i] <= '0;
      end
      stg_sat_q <= '0;
      ykt_q     <= '0;
      satu_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      acc_q     <= acc_d;
      e_q       <= e_d;
      satp_q    <= satp_d;
      ref_q     <= ref_d;
      pot_q     <= pot_d;
      a0_q      <= a0_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      modo_q    <= modo_d;
      e1_q      <= e1_d;
      e2_q      <= e2_d;
      y1_q      <= y1_d;
      stg_q     <= stg_d;
      stg_sat_q <= stg_sat_d;
      ykt_q     <= ykt_d;
      satu_q    <= satu_d;
      ovr_q     <= ovr_d;
    end
  end

  assign YkT      = ykt_q;
  assign Listo    = (state_q == S_DONE);
  assign Ocupado  = (state_q != S_IDLE);
  assign Overrun  = ovr_q;
  assign Saturado = satu_q;

endmodule

// File: tb/tb_servo_pid_multicanal.sv
// Testbench for servo_pid_multicanal: directed scenarios plus random
// periods, all checked against an integer-arithmetic model of the PID law.
module tb_servo_pid_multicanal;
  localparam int CB = 13;
  localparam int FB = 8;
  localparam int NC = 2;
  localparam int LAT = 5*NC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_tick = 1'b0;
  logic modo = 1'b0;
  logic [NC*CB-1:0] ref_p = '0, pot_p = '0, ykt;
  logic [CB-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic listo, ocupado, overrun;
  logic [NC-1:0] saturado;

  always #5 clk = ~clk;

  servo_pid_multicanal #(.CANT_BITS(CB), .FRAC_BITS(FB), .N_CH(NC)) dut (
    .Clk_P(clk), .Rst_P(rst_n), .Rx_Tick(rx_tick), .Modo(modo),
    .Ref_P(ref_p), .Pot_P(pot_p), .Coef_A0(a0), .Coef_A1(a1), .Coef_A2(a2),
    .YkT(ykt), .Listo(listo), .Ocupado(ocupado), .Overrun(overrun),
    .Saturado(saturado)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_e1 [NC];
  int m_e2 [NC];
  int m_y1 [NC];
  int exp_y [NC];
  bit exp_s [NC];

  // Observations of the last period
  int ob_lat, ob_listo_cnt, ob_ovr_cnt;
  bit ob_ocup_ok;
  logic [NC*CB-1:0] ob_ykt;
  logic [NC-1:0] ob_sat;

  function automatic int clampi(input int v);
    int hi = (1 << (CB-1)) - 1;
    int lo = -(1 << (CB-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_e1[c] = 0; m_e2[c] = 0; m_y1[c] = 0; exp_y[c] = 0; exp_s[c] = 1'b0;
    end
  endtask

  task automatic model_period(input logic [NC*CB-1:0] r, input logic [NC*CB-1:0] p,
                              input int k0, input int k1, input int k2, input bit md);
    int rv, pv, d, e, acc, q, y;
    for (int c = 0; c < NC; c++) begin
      rv = int'($signed(r[c*CB +: CB]));
      pv = int'($signed(p[c*CB +: CB]));
      if (md) begin
        exp_y[c] = rv;
        exp_s[c] = 1'b0;
      end else begin
        d = rv - pv;
        e = clampi(d);
        acc = m_y1[c]*256 + k0*e + k1*m_e1[c] + k2*m_e2[c];
        q = acc / 256;
        if (acc < 0 && q*256 != acc) q = q - 1;
        y = clampi(q);
        exp_y[c] = y;
        exp_s[c] = (e != d) || (y != q);
        m_y1[c] = y;
        m_e2[c] = m_e1[c];
        m_e1[c] = e;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One full period: drive, scramble inputs after capture, observe 20 cycles.
  task automatic run_period(input bit md, input int k0, input int k1, input int k2,
                            input logic [NC*CB-1:0] r, input logic [NC*CB-1:0] p,
                            input bit retick);
    int tmp;
    @(negedge clk);
    modo = md; ref_p = r; pot_p = p;
    tmp = k0; a0 = tmp[CB-1:0];
    tmp = k1; a1 = tmp[CB-1:0];
    tmp = k2; a2 = tmp[CB-1:0];
    rx_tick = 1'b1;
    ob_lat = 0; ob_listo_cnt = 0; ob_ovr_cnt = 0; ob_ocup_ok = 1'b1;
    ob_ykt = '0; ob_sat = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (listo === 1'b1) begin
        ob_listo_cnt++;
        if (ob_lat == 0) begin ob_lat = n; ob_ykt = ykt; ob_sat = saturado; end
      end
      if (overrun === 1'b1) ob_ovr_cnt++;
      if (ocupado !== (n <= LAT)) ob_ocup_ok = 1'b0;
      rx_tick = retick && (n == 3);
      if (n == 1) begin
        ref_p = (NC*CB)'($urandom()); pot_p = (NC*CB)'($urandom());
        a0 = CB'($urandom()); a1 = CB'($urandom()); a2 = CB'($urandom());
        modo = ~md;
      end
    end
    model_period(r, p, k0, k1, k2, md);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (ykt !== '0 || listo !== 1'b0 || ocupado !== 1'b0 || overrun !== 1'b0 || saturado !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ykt=%h listo=%b ocupado=%b overrun=%b sat=%b, want all 0",
               ykt, listo, ocupado, overrun, saturado);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_tick();
    run_period(1'b0, 256, 0, 0, {NC{13'sd2560}}, {NC{13'sd2048}}, 1'b0);
    vectors++;
    if (ob_lat !== LAT || ob_listo_cnt !== 1) begin
      miscompares++;
      $display("FAIL first_latency: lat=%0d pulses=%0d, want lat=%0d pulses=1", ob_lat, ob_listo_cnt, LAT);
    end
    vectors++;
    if (!ob_ocup_ok) begin
      miscompares++;
      $display("FAIL first_ocupado: busy window wrong, want high for cycles 1..%0d only", LAT);
    end
    for (int c = 0; c < NC; c++) begin
      vectors++;
      if (ob_ykt[c*CB +: CB] !== exp_y[c][CB-1:0] || ob_sat[c] !== exp_s[c]) begin
        miscompares++;
        $display("FAIL first_ykt ch%0d: got %0d sat=%b, want %0d sat=%b",
                 c, $signed(ob_ykt[c*CB +: CB]), ob_sat[c], exp_y[c], exp_s[c]);
      end
    end
  endtask

  task automatic test_accumulate_saturate();
    for (int t = 2; t <= 9; t++) begin
      run_period(1'b0, 256, 0, 0, {NC{13'sd2560}}, {NC{13'sd2048}}, 1'b0);
      for (int c = 0; c < NC; c++) begin
        vectors++;
        if (ob_lat !== LAT || ob_ykt[c*CB +: CB] !== exp_y[c][CB-1:0] || ob_sat[c] !== exp_s[c]) begin
          miscompares++;
          $display("FAIL accum tick%0d ch%0d: got %0d sat=%b lat=%0d, want %0d sat=%b lat=%0d",
                   t, c, $signed(ob_ykt[c*CB +: CB]), ob_sat[c], ob_lat, exp_y[c], exp_s[c], LAT);
        end
      end
    end
    vectors++;
    if (ykt !== ob_ykt) begin
      miscompares++;
      $display("FAIL ykt_hold: got %h, want %h held after update", ykt, ob_ykt);
    end
  endtask

  task automatic test_error_clip();
    do_reset();
    run_period(1'b0, 256, 0, 0, {NC{13'sd4095}}, {NC{-13'sd4096}}, 1'b0);
    for (int c = 0; c < NC; c++) begin
      vectors++;
      if (ob_ykt[c*CB +: CB] !== exp_y[c][CB-1:0] || ob_sat[c] !== exp_s[c]) begin
        miscompares++;
        $display("FAIL err_clip ch%0d: got %0d sat=%b, want %0d sat=%b",
                 c, $signed(ob_ykt[c*CB +: CB]), ob_sat[c], exp_y[c], exp_s[c]);
      end
    end
  endtask

  task automatic test_pid_step();
    logic [NC*CB-1:0] r, p;
    do_reset();
    r = {NC{13'sd100}}; p = {NC{13'sd100}};
    r[0 +: CB] = 13'sd256; p[0 +: CB] = '0;
    for (int t = 1; t <= 3; t++) begin
      run_period(1'b0, 384, -256, 64, r, p, 1'b0);
      for (int c = 0; c < NC; c++) begin
        vectors++;
        if (ob_ykt[c*CB +: CB] !== exp_y[c][CB-1:0] || ob_sat[c] !== exp_s[c]) begin
          miscompares++;
          $display("FAIL pid_step tick%0d ch%0d: got %0d sat=%b, want %0d sat=%b",
                   t, c, $signed(ob_ykt[c*CB +: CB]), ob_sat[c], exp_y[c], exp_s[c]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [NC*CB-1:0] r;
    r = (NC*CB)'($urandom());
    run_period(1'b1, 256, 0, 0, r, (NC*CB)'($urandom()), 1'b0);
    vectors++;
    if (ob_lat !== LAT || ob_ykt !== r || ob_sat !== '0) begin
      miscompares++;
      $display("FAIL bypass: got %h sat=%b lat=%0d, want %h sat=0 lat=%0d", ob_ykt, ob_sat, ob_lat, r, LAT);
    end
    // A closed-loop period afterwards shows whether histories were left alone.
    run_period(1'b0, 100, -50, 20, {NC{13'sd300}}, {NC{13'sd0}}, 1'b0);
    for (int c = 0; c < NC; c++) begin
      vectors++;
      if (ob_ykt[c*CB +: CB] !== exp_y[c][CB-1:0] || ob_sat[c] !== exp_s[c]) begin
        miscompares++;
        $display("FAIL after_bypass ch%0d: got %0d sat=%b, want %0d sat=%b",
                 c, $signed(ob_ykt[c*CB +: CB]), ob_sat[c], exp_y[c], exp_s[c]);
      end
    end
  endtask

  task automatic test_overrun();
    run_period(1'b0, 256, 0, 0, {NC{13'sd200}}, {NC{13'sd50}}, 1'b1);
    vectors++;
    if (ob_ovr_cnt !== 1 || ob_listo_cnt !== 1 || ob_lat !== LAT) begin
      miscompares++;
      $display("FAIL overrun: ovr=%0d listo=%0d lat=%0d, want ovr=1 listo=1 lat=%0d",
               ob_ovr_cnt, ob_listo_cnt, ob_lat, LAT);
    end
    for (int c = 0; c < NC; c++) begin
      vectors++;
      if (ob_ykt[c*CB +: CB] !== exp_y[c][CB-1:0]) begin
        miscompares++;
        $display("FAIL overrun_ykt ch%0d: got %0d, want %0d", c, $signed(ob_ykt[c*CB +: CB]), exp_y[c]);
      end
    end
  endtask

  task automatic test_reset_mid_period();
    int pulses = 0;
    @(negedge clk);
    modo = 1'b0; ref_p = {NC{13'sd1000}}; pot_p = '0; a0 = 13'd256; a1 = '0; a2 = '0;
    rx_tick = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      rx_tick = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ykt !== '0 || listo !== 1'b0 || ocupado !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: ykt=%h listo=%b ocupado=%b, want 0", ykt, listo, ocupado);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (listo === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0 || ykt !== '0) begin
      miscompares++;
      $display("FAIL reset_abandon: listo pulses=%0d ykt=%h, want 0 and 0", pulses, ykt);
    end
    run_period(1'b0, 256, 0, 0, {NC{13'sd2560}}, {NC{13'sd2048}}, 1'b0);
    for (int c = 0; c < NC; c++) begin
      vectors++;
      if (ob_lat !== LAT || ob_ykt[c*CB +: CB] !== exp_y[c][CB-1:0]) begin
        miscompares++;
        $display("FAIL post_reset ch%0d: got %0d lat=%0d, want %0d lat=%0d",
                 c, $signed(ob_ykt[c*CB +: CB]), ob_lat, exp_y[c], LAT);
      end
    end
  endtask

  task automatic test_random();
    int k0, k1, k2;
    bit md;
    for (int t = 0; t < 25; t++) begin
      k0 = int'($urandom_range(8191)) - 4096;
      k1 = int'($urandom_range(8191)) - 4096;
      k2 = int'($urandom_range(8191)) - 4096;
      md = ($urandom_range(3) == 0);
      run_period(md, k0, k1, k2, (NC*CB)'($urandom()), (NC*CB)'($urandom()), 1'b0);
      for (int c = 0; c < NC; c++) begin
        vectors++;
        if (ob_lat !== LAT || ob_ykt[c*CB +: CB] !== exp_y[c][CB-1:0] || ob_sat[c] !== exp_s[c]) begin
          miscompares++;
          $display("FAIL random%0d ch%0d: got %0d sat=%b lat=%0d, want %0d sat=%b lat=%0d",
                   t, c, $signed(ob_ykt[c*CB +: CB]), ob_sat[c], ob_lat, exp_y[c], exp_s[c], LAT);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_tick();
    test_accumulate_saturate();
    test_error_clip();
    test_pid_step();
    test_bypass();
    test_overrun();
    test_reset_mid_period();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
